// File: rtl/membus_arbiter.sv
// Two-master round-robin arbiter for the single-cycle-handshake memory bus.
// One transaction is granted at a time. The slave response is routed back
// to the owning master. A watchdog aborts transactions the slave never completes.
module membus_arbiter #(
   parameter int unsigned TIMEOUT       = 256,
   parameter logic [31:0] TIMEOUT_RDATA = 32'hDEAD_BEEF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] m0_addr,
   input  logic [2:0]  m0_size,
   input  logic        m0_valid,
   input  logic        m0_write,
   input  logic [31:0] m0_wdata,
   output logic [31:0] m0_rdata,
   output logic        m0_ready,
   input  logic [31:0] m1_addr,
   input  logic [2:0]  m1_size,
   input  logic        m1_valid,
   input  logic        m1_write,
   input  logic [31:0] m1_wdata,
   output logic [31:0] m1_rdata,
   output logic        m1_ready,
   output logic [31:0] s_addr,
   output logic [2:0]  s_size,
   output logic        s_write,
   output logic [31:0] s_wdata,
   output logic        s_valid,
   input  logic [31:0] s_rdata,
   input  logic        s_ready,
   output logic [1:0]  gnt,
   output logic        timeout_err
);

   // Counter only has to reach TIMEOUT-1; keep at least one bit when disabled.
   localparam int unsigned    CW       = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [CW-1:0]  CNT_LAST = CW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

   typedef enum logic [1:0] {IDLE, BUSY0, BUSY1} state_t;

   state_t         state, state_nxt;
   logic           ptr, ptr_nxt;
   logic [CW-1:0]  cnt;
   logic           done;
   logic           abort;
   logic [31:0]    done_rdata;

   // State, priority pointer, watchdog count and sticky error flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         ptr         <= 1'b0;
         cnt         <= '0;
         timeout_err <= 1'b0;
      end else begin
         state       <= state_nxt;
         ptr         <= ptr_nxt;
         // IDLE always precedes BUSYn, so clearing here zeroes cnt on entry.
         cnt         <= (state == IDLE) ? '0 : cnt + CW'(1);
         timeout_err <= timeout_err | abort;
      end
   end

   // Arbitration, slave mux, completion routing and next-state logic.
   always_comb begin
      state_nxt  = state;
      ptr_nxt    = ptr;
      done       = 1'b0;
      abort      = 1'b0;
      done_rdata = '0;
      s_addr     = '0;
      s_size     = '0;
      s_write    = 1'b0;
      s_wdata    = '0;
      s_valid    = 1'b0;
      gnt        = 2'b00;
      m0_ready   = 1'b0;
      m0_rdata   = '0;
      m1_ready   = 1'b0;
      m1_rdata   = '0;

      case (state)
         IDLE: begin
            if (m0_valid && m1_valid)
               state_nxt = ptr ? BUSY1 : BUSY0;
            else if (m0_valid)
               state_nxt = BUSY0;
            else if (m1_valid)
               state_nxt = BUSY1;
         end
         BUSY0, BUSY1: begin
            s_valid = 1'b1;
            if (state == BUSY1) begin
               s_addr  = m1_addr;
               s_size  = m1_size;
               s_write = m1_write;
               s_wdata = m1_wdata;
               gnt     = 2'b10;
            end else begin
               s_addr  = m0_addr;
               s_size  = m0_size;
               s_write = m0_write;
               s_wdata = m0_wdata;
               gnt     = 2'b01;
            end
            // A real completion takes precedence over a same-cycle watchdog expiry.
            if (s_ready) begin
               done       = 1'b1;
               done_rdata = s_rdata;
            end else if ((TIMEOUT != 0) && (cnt == CNT_LAST)) begin
               done       = 1'b1;
               abort      = 1'b1;
               done_rdata = TIMEOUT_RDATA;
            end
            if (done) begin
               state_nxt = IDLE;
               ptr_nxt   = (state == BUSY0);
               if (state == BUSY1) begin
                  m1_ready = 1'b1;
                  m1_rdata = done_rdata;
               end else begin
                  m0_ready = 1'b1;
                  m0_rdata = done_rdata;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

endmodule

// File: tb/tb_membus_arbiter.sv
// Bench for membus_arbiter: three instances (TIMEOUT 8, 4, 0) share the
// stimulus. Each scenario task checks the instance it targets.
module tb_membus_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata, s_rdata;
   logic [2:0]  m0_size, m1_size;
   logic        m0_valid, m1_valid, m0_write, m1_write, s_ready;

   logic [31:0] o_m0_rdata [3];
   logic [31:0] o_m1_rdata [3];
   logic        o_m0_ready [3];
   logic        o_m1_ready [3];
   logic [31:0] o_s_addr   [3];
   logic [2:0]  o_s_size   [3];
   logic        o_s_write  [3];
   logic [31:0] o_s_wdata  [3];
   logic        o_s_valid  [3];
   logic [1:0]  o_gnt      [3];
   logic        o_err      [3];

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   // Instance 0: TIMEOUT=8, instance 1: TIMEOUT=4, instance 2: watchdog off.
   for (genvar g = 0; g < 3; g++) begin : g_dut
      membus_arbiter #(.TIMEOUT((g == 0) ? 8 : (g == 1) ? 4 : 0)) u_dut (
         .clk(clk), .rst(rst),
         .m0_addr(m0_addr), .m0_size(m0_size), .m0_valid(m0_valid),
         .m0_write(m0_write), .m0_wdata(m0_wdata),
         .m0_rdata(o_m0_rdata[g]), .m0_ready(o_m0_ready[g]),
         .m1_addr(m1_addr), .m1_size(m1_size), .m1_valid(m1_valid),
         .m1_write(m1_write), .m1_wdata(m1_wdata),
         .m1_rdata(o_m1_rdata[g]), .m1_ready(o_m1_ready[g]),
         .s_addr(o_s_addr[g]), .s_size(o_s_size[g]), .s_write(o_s_write[g]),
         .s_wdata(o_s_wdata[g]), .s_valid(o_s_valid[g]),
         .s_rdata(s_rdata), .s_ready(s_ready),
         .gnt(o_gnt[g]), .timeout_err(o_err[g])
      );
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      m0_addr = '0; m0_size = '0; m0_valid = 1'b0; m0_write = 1'b0; m0_wdata = '0;
      m1_addr = '0; m1_size = '0; m1_valid = 1'b0; m1_write = 1'b0; m1_wdata = '0;
      s_rdata = '0; s_ready = 1'b0;
   endtask

   task automatic do_reset();
      idle_inputs();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      idle_inputs();
      m0_valid = 1'b1; m1_valid = 1'b1; m0_addr = $urandom; m1_addr = $urandom;
      s_ready = 1'b1; s_rdata = $urandom;
      rst = 1'b1;
      tick();
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
         checks++;
         if ({o_gnt[k], o_s_valid[k], o_s_write[k], o_s_size[k], o_err[k]} !== 8'h00) begin
            errors++;
            $display("FAIL reset_ctrl dut%0d got gnt=%b sv=%b sw=%b sz=%0d err=%b want all 0",
                     k, o_gnt[k], o_s_valid[k], o_s_write[k], o_s_size[k], o_err[k]);
         end
         checks++;
         if ({o_s_addr[k], o_s_wdata[k]} !== 64'h0) begin
            errors++;
            $display("FAIL reset_slave dut%0d got addr=%h wdata=%h want 0", k, o_s_addr[k], o_s_wdata[k]);
         end
         checks++;
         if ({o_m0_ready[k], o_m1_ready[k], o_m0_rdata[k], o_m1_rdata[k]} !== 66'h0) begin
            errors++;
            $display("FAIL reset_master dut%0d got r0=%b r1=%b d0=%h d1=%h want 0",
                     k, o_m0_ready[k], o_m1_ready[k], o_m0_rdata[k], o_m1_rdata[k]);
         end
      end
      idle_inputs();
      tick();
      rst = 1'b0;
   endtask

   task automatic test_single();
      logic busy;
      do_reset();
      m0_valid = 1'b1; m0_addr = 32'h1004; m0_write = 1'b0; m0_size = 3'd2;
      for (int c = 0; c < 6; c++) begin
         s_ready = (c == 3);
         s_rdata = (c == 3) ? 32'h1234_5678 : $urandom;
         busy = (c >= 1 && c <= 3);
         @(negedge clk);
         checks++;
         if ({o_s_valid[0], o_gnt[0]} !== (busy ? 3'b101 : 3'b000)) begin
            errors++;
            $display("FAIL single_gnt c=%0d got sv=%b gnt=%b want busy=%b", c, o_s_valid[0], o_gnt[0], busy);
         end
         checks++;
         if (o_s_addr[0] !== (busy ? 32'h1004 : 32'h0)) begin
            errors++;
            $display("FAIL single_addr c=%0d got %h want %h", c, o_s_addr[0], busy ? 32'h1004 : 32'h0);
         end
         checks++;
         if ({o_m0_ready[0], o_m0_rdata[0]} !== {(c == 3), ((c == 3) ? 32'h1234_5678 : 32'h0)}) begin
            errors++;
            $display("FAIL single_resp c=%0d got rdy=%b rdata=%h want rdy=%b", c, o_m0_ready[0], o_m0_rdata[0], c == 3);
         end
         checks++;
         if ({o_m1_ready[0], o_m1_rdata[0]} !== 33'h0) begin
            errors++;
            $display("FAIL single_m1 c=%0d got rdy=%b rdata=%h want 0", c, o_m1_ready[0], o_m1_rdata[0]);
         end
         tick();
         if (c == 3) m0_valid = 1'b0;
      end
      idle_inputs();
   endtask

   task automatic test_contention();
      logic [31:0] wd0 [4];
      logic [31:0] wd1 [4];
      int i0, i1, ph, t, own;
      logic busy;
      logic [31:0] ea, ew;
      for (int i = 0; i < 4; i++) begin
         wd0[i] = $urandom;
         wd1[i] = $urandom;
      end
      do_reset();
      i0 = 0; i1 = 0;
      m0_valid = 1'b1; m0_write = 1'b1; m0_addr = 32'h1000; m0_wdata = wd0[0];
      m1_valid = 1'b1; m1_write = 1'b1; m1_addr = 32'h2000; m1_wdata = wd1[0];
      for (int c = 0; c < 27; c++) begin
         ph = c % 3; t = c / 3; own = t % 2;
         busy = (ph != 0) && (t < 8);
         s_ready = busy && (ph == 2);
         s_rdata = $urandom;
         ea = !busy ? 32'h0 : (own == 0) ? 32'h1000 + 32'(4 * (t / 2)) : 32'h2000 + 32'(4 * (t / 2));
         ew = !busy ? 32'h0 : (own == 0) ? wd0[t / 2] : wd1[t / 2];
         @(negedge clk);
         checks++;
         if ({o_s_valid[0], o_gnt[0]} !== (!busy ? 3'b000 : (own == 0) ? 3'b101 : 3'b110)) begin
            errors++;
            $display("FAIL cont_gnt c=%0d got sv=%b gnt=%b want busy=%b own=%0d", c, o_s_valid[0], o_gnt[0], busy, own);
         end
         checks++;
         if ({o_s_addr[0], o_s_wdata[0], o_s_write[0]} !== {ea, ew, busy}) begin
            errors++;
            $display("FAIL cont_data c=%0d got a=%h w=%h wr=%b want a=%h w=%h wr=%b",
                     c, o_s_addr[0], o_s_wdata[0], o_s_write[0], ea, ew, busy);
         end
         checks++;
         if ({o_m0_ready[0], o_m1_ready[0]} !== {s_ready && own == 0, s_ready && own == 1}) begin
            errors++;
            $display("FAIL cont_ready c=%0d got r0=%b r1=%b want own=%0d done=%b", c, o_m0_ready[0], o_m1_ready[0], own, s_ready);
         end
         tick();
         if (busy && ph == 2) begin
            if (own == 0) begin
               i0++;
               if (i0 == 4) m0_valid = 1'b0;
               else begin m0_addr = 32'h1000 + 32'(4 * i0); m0_wdata = wd0[i0]; end
            end else begin
               i1++;
               if (i1 == 4) m1_valid = 1'b0;
               else begin m1_addr = 32'h2000 + 32'(4 * i1); m1_wdata = wd1[i1]; end
            end
         end
      end
      idle_inputs();
   endtask

   task automatic test_timeout();
      logic busy, dn;
      do_reset();
      m1_valid = 1'b1; m1_write = 1'b0; m1_addr = 32'h2040;
      for (int c = 0; c < 12; c++) begin
         s_rdata = $urandom;
         busy = (c >= 1 && c <= 8);
         dn = (c == 8);
         @(negedge clk);
         checks++;
         if (o_gnt[0] !== (busy ? 2'b10 : 2'b00)) begin
            errors++;
            $display("FAIL tmo_gnt c=%0d got %b want busy=%b", c, o_gnt[0], busy);
         end
         checks++;
         if ({o_m1_ready[0], o_m1_rdata[0]} !== {dn, (dn ? 32'hDEAD_BEEF : 32'h0)}) begin
            errors++;
            $display("FAIL tmo_resp c=%0d got rdy=%b rdata=%h want rdy=%b", c, o_m1_ready[0], o_m1_rdata[0], dn);
         end
         checks++;
         if (o_err[0] !== (c >= 9)) begin
            errors++;
            $display("FAIL tmo_err c=%0d got %b want %b", c, o_err[0], c >= 9);
         end
         tick();
         if (c == 8) m1_valid = 1'b0;
      end
      do_reset();
      @(negedge clk);
      checks++;
      if (o_err[0] !== 1'b0) begin
         errors++;
         $display("FAIL tmo_err_clear got %b want 0", o_err[0]);
      end
      m0_valid = 1'b1; m1_valid = 1'b1;
      tick();
      @(negedge clk);
      checks++;
      if (o_gnt[0] !== 2'b01) begin
         errors++;
         $display("FAIL tmo_next_gnt got %b want 01", o_gnt[0]);
      end
      idle_inputs();
      do_reset();
   endtask

   task automatic test_collision();
      do_reset();
      m0_valid = 1'b1; m0_addr = 32'h3000;
      for (int c = 0; c < 6; c++) begin
         s_ready = (c == 4);
         s_rdata = (c == 4) ? 32'hCAFE_0001 : $urandom;
         @(negedge clk);
         checks++;
         if ({o_m0_ready[1], o_m0_rdata[1]} !== {(c == 4), ((c == 4) ? 32'hCAFE_0001 : 32'h0)}) begin
            errors++;
            $display("FAIL coll_resp c=%0d got rdy=%b rdata=%h want rdy=%b", c, o_m0_ready[1], o_m0_rdata[1], c == 4);
         end
         checks++;
         if (o_err[1] !== 1'b0) begin
            errors++;
            $display("FAIL coll_err c=%0d got %b want 0", c, o_err[1]);
         end
         tick();
         if (c == 4) m0_valid = 1'b0;
      end
      idle_inputs();
   endtask

   task automatic test_reset_mid();
      do_reset();
      m0_valid = 1'b1;
      tick();
      s_ready = 1'b1; s_rdata = 32'h5555_AAAA;
      @(negedge clk);
      checks++;
      if (o_m0_ready[0] !== 1'b1) begin
         errors++;
         $display("FAIL rmid_first got rdy=%b want 1", o_m0_ready[0]);
      end
      tick();
      m0_valid = 1'b0; s_ready = 1'b0;
      m1_valid = 1'b1;
      tick();
      tick();
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if ({o_gnt[0], o_m1_ready[0]} !== 3'b100) begin
         errors++;
         $display("FAIL rmid_busy got gnt=%b r1=%b want gnt=10 r1=0", o_gnt[0], o_m1_ready[0]);
      end
      tick();
      rst = 1'b0;
      m0_valid = 1'b1;
      @(negedge clk);
      checks++;
      if ({o_s_valid[0], o_gnt[0], o_m0_ready[0], o_m1_ready[0]} !== 5'b0) begin
         errors++;
         $display("FAIL rmid_after got sv=%b gnt=%b r0=%b r1=%b want 0", o_s_valid[0], o_gnt[0], o_m0_ready[0], o_m1_ready[0]);
      end
      tick();
      @(negedge clk);
      checks++;
      if (o_gnt[0] !== 2'b01) begin
         errors++;
         $display("FAIL rmid_next_gnt got %b want 01", o_gnt[0]);
      end
      idle_inputs();
      do_reset();
   endtask

   task automatic test_wdog_off();
      int bad;
      do_reset();
      m0_valid = 1'b1; m0_addr = 32'h4000;
      tick();
      bad = 0;
      for (int c = 0; c < 1000; c++) begin
         s_rdata = $urandom;
         @(negedge clk);
         if ({o_s_valid[2], o_gnt[2], o_m0_ready[2], o_err[2]} !== 5'b10100) bad++;
         tick();
      end
      checks++;
      if (bad !== 0) begin
         errors++;
         $display("FAIL wdog_stall got %0d bad cycles want 0", bad);
      end
      s_ready = 1'b1; s_rdata = 32'h0BAD_F00D;
      @(negedge clk);
      checks++;
      if ({o_m0_ready[2], o_m0_rdata[2]} !== {1'b1, 32'h0BAD_F00D}) begin
         errors++;
         $display("FAIL wdog_done got rdy=%b rdata=%h want 1 0badf00d", o_m0_ready[2], o_m0_rdata[2]);
      end
      tick();
      idle_inputs();
      @(negedge clk);
      checks++;
      if ({o_gnt[2], o_err[2]} !== 3'b000) begin
         errors++;
         $display("FAIL wdog_idle got gnt=%b err=%b want 0", o_gnt[2], o_err[2]);
      end
      tick();
   endtask

   // Random traffic on the TIMEOUT=4 instance against a transaction-level model.
   task automatic test_random();
      int own, pref, age;
      logic err, dn, ab;
      logic [31:0] rd;
      logic [1:0]  eg;
      logic [31:0] ea, ew;
      logic [2:0]  es;
      logic        ewr;
      do_reset();
      own = -1; pref = 0; age = 0; err = 1'b0;
      for (int c = 0; c < 400; c++) begin
         if (!m0_valid && $urandom_range(0, 2) == 0) begin
            m0_valid = 1'b1; m0_addr = $urandom; m0_size = 3'($urandom_range(0, 7));
            m0_write = 1'($urandom_range(0, 1)); m0_wdata = $urandom;
         end
         if (!m1_valid && $urandom_range(0, 2) == 0) begin
            m1_valid = 1'b1; m1_addr = $urandom; m1_size = 3'($urandom_range(0, 7));
            m1_write = 1'($urandom_range(0, 1)); m1_wdata = $urandom;
         end
         s_ready = ($urandom_range(0, 3) == 0);
         s_rdata = $urandom;
         eg = 2'b00; ea = '0; ew = '0; es = '0; ewr = 1'b0;
         dn = 1'b0; ab = 1'b0; rd = '0;
         if (own >= 0) begin
            eg  = (own == 0) ? 2'b01 : 2'b10;
            ea  = (own == 0) ? m0_addr  : m1_addr;
            ew  = (own == 0) ? m0_wdata : m1_wdata;
            es  = (own == 0) ? m0_size  : m1_size;
            ewr = (own == 0) ? m0_write : m1_write;
            if (s_ready) begin dn = 1'b1; rd = s_rdata; end
            else if (age == 3) begin dn = 1'b1; ab = 1'b1; rd = 32'hDEAD_BEEF; end
         end
         @(negedge clk);
         checks++;
         if ({o_gnt[1], o_s_valid[1], o_s_addr[1], o_s_size[1], o_s_write[1], o_s_wdata[1]} !==
             {eg, (own >= 0), ea, es, ewr, ew}) begin
            errors++;
            $display("FAIL rnd_slave c=%0d got gnt=%b a=%h sz=%0d wr=%b w=%h want gnt=%b a=%h sz=%0d wr=%b w=%h",
                     c, o_gnt[1], o_s_addr[1], o_s_size[1], o_s_write[1], o_s_wdata[1], eg, ea, es, ewr, ew);
         end
         checks++;
         if ({o_m0_ready[1], o_m0_rdata[1], o_m1_ready[1], o_m1_rdata[1]} !==
             {dn && own == 0, (dn && own == 0) ? rd : 32'h0, dn && own == 1, (dn && own == 1) ? rd : 32'h0}) begin
            errors++;
            $display("FAIL rnd_master c=%0d got r0=%b d0=%h r1=%b d1=%h want own=%0d done=%b rd=%h",
                     c, o_m0_ready[1], o_m0_rdata[1], o_m1_ready[1], o_m1_rdata[1], own, dn, rd);
         end
         checks++;
         if (o_err[1] !== err) begin
            errors++;
            $display("FAIL rnd_err c=%0d got %b want %b", c, o_err[1], err);
         end
         tick();
         if (own < 0) begin
            if (m0_valid && m1_valid) own = pref;
            else if (m0_valid) own = 0;
            else if (m1_valid) own = 1;
            age = 0;
         end else if (dn) begin
            if (own == 0) m0_valid = 1'b0;
            else m1_valid = 1'b0;
            pref = 1 - own;
            err = err | ab;
            own = -1;
         end else begin
            age++;
         end
      end
      idle_inputs();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL global_timeout got no finish want finish");
      $fatal(1, "bench time limit");
   end

   initial begin
      rst = 1'b1;
      idle_inputs();
      test_reset();
      test_single();
      test_contention();
      test_timeout();
      test_collision();
      test_reset_mid();
      test_wdog_off();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/membus_arbiter.md
# membus_arbiter

Two-master round-robin arbiter for the single-cycle-handshake memory bus (addr/size/valid/write/wdata/rdata/ready) between processor cores and the RAM/MMIO decode. It lets a second requester share one slave port with the core: a DMA engine, or a second core. The slave port connects unchanged to the existing RAM and peripheral mux. It grants one transaction at a time, routes the slave response back to the owning master, and aborts hung transactions with a watchdog.

## Interface
- TIMEOUT, 256: slave cycles allowed per transaction before abort; 0 disables the watchdog.
- TIMEOUT_RDATA, 32'hDEAD_BEEF: rdata returned to a master on a timed-out transaction.
- clk  input  1  rising-edge clock.
- rst  input  1  one clock; reset is synchronous and active-high.
- m0_addr, m1_addr  input  32  master byte address.
- m0_size, m1_size  input  3  access size (passed through).
- m0_valid, m1_valid  input  1  request; held high with addr/size/write/wdata stable until mN_ready.
- m0_write, m1_write  input  1  1 = write.
- m0_wdata, m1_wdata  input  32  write data.
- m0_rdata, m1_rdata  output  32  read data; 0 when the master is not being completed.
- m0_ready, m1_ready  output  1  one-cycle completion pulse.
- s_addr, s_size, s_write, s_wdata  output  32/3/1/32  muxed from the granted master; 0 when idle.
- s_valid  output  1  high for every BUSY cycle.
- s_rdata  input  32  slave read data.
- s_ready  input  1  slave completion, sampled only while s_valid.
- gnt  output  2  one-hot current owner ({m1,m0}); 2'b00 when idle.
- timeout_err  output  1  sticky; set on any watchdog abort, cleared only by rst.

## Operation
- States: IDLE, BUSY0, BUSY1, held in a registered state with a registered priority pointer ptr (0 = m0 preferred).
- IDLE:
  - No valid: stay.
  - One valid: go to BUSYn for that master.
  - Both valid: go to BUSY[ptr].
- BUSYn:
  - s_valid=1, slave outputs driven from master n, gnt[n]=1, wdog counter cnt increments each cycle.
  - s_ready=1: mn_ready=1 and mn_rdata=s_rdata that cycle. Next state IDLE, ptr ← ~n (served master becomes lowest priority).
  - Otherwise, if TIMEOUT≠0 and cnt==TIMEOUT-1: abort. mn_ready=1 and mn_rdata=TIMEOUT_RDATA that cycle. Next state IDLE, ptr ← ~n, timeout_err ← 1.
  - Otherwise stay.
  - s_ready wins over timeout in the same cycle (no err).
- cnt clears on entry to BUSYn. Its width is sized to hold TIMEOUT-1 with no wrap.
- The non-granted master's ready stays 0 and its rdata stays 0 throughout.
- A master dropping valid mid-transaction is a protocol violation. The arbiter does not watch valid in BUSY; it keeps driving the latched master's current inputs until s_ready or timeout.
- Reset values: state IDLE, ptr 0, cnt 0, timeout_err 0. All outputs 0.

## Timing
- Grant latency: mN_valid high in IDLE at edge t → s_valid high from cycle t+1.
- Completion is combinational from s_ready: mN_ready and mN_rdata in the same cycle as s_ready.
- Round trip is 1 + slave latency cycles.
- One mandatory IDLE bubble after each completion, so back-to-back transactions start at least 2 cycles apart. The completing master's still-high valid is never re-sampled in its ready cycle.
- Timeout abort asserts mN_ready in the TIMEOUT-th BUSY cycle. timeout_err is visible from the following cycle.
- rst asserted at any edge:
  - The next cycle is IDLE with all outputs 0.
  - The in-flight transaction is dropped and no mN_ready is issued.
  - ptr returns to 0.

## Test plan
- Single master: m0 reads addr 'h1004 and the slave returns ready 2 cycles after s_valid with rdata 'h12345678. Required: s_valid from t+1, m0_ready pulse one cycle with m0_rdata 'h12345678, m1_ready never asserted, gnt=01 only during BUSY.
- Contention: m0 and m1 both valid from reset, each issuing 4 writes, slave ready 1 cycle after s_valid. Required: grants alternate m0,m1,m0,m1,…, starting with m0, with one IDLE cycle between transactions and s_addr/s_wdata matching the owner each time.
- Timeout: TIMEOUT=8, m1 reads and the slave never asserts ready. Required: m1_ready in the 8th BUSY cycle with m1_rdata 'hDEADBEEF, timeout_err=1 from the next cycle and held until rst, after which the next grant goes to m0.
- Ready/timeout collision: TIMEOUT=4, slave ready exactly in the 4th BUSY cycle. Required: m0_rdata = s_rdata and timeout_err stays 0.
- Reset mid-operation: rst for 1 cycle while in BUSY1. Required: s_valid=0 and gnt=00 next cycle, no m1_ready pulse, and with both masters valid afterwards the next grant goes to m0.
- Watchdog disabled: TIMEOUT=0 with a slave stalled for 1000 cycles. Required: the arbiter stays in BUSY with no abort, and completes normally when s_ready finally arrives.
